// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream (taps 15 and 4).
// Optional error counter and clear input are built when LFSR_CHECK_ERRCNT_EN is defined.
module lfsr_checker #(
  parameter int CONFIRM_BITS = 16,
  parameter int LOSS_THRESH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_bit,
  input  logic        i_clr,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_err_count,
  output logic [15:0] o_state_value
);

  localparam int CW = $clog2(CONFIRM_BITS + 1);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  localparam logic [CW-1:0] MATCH_LAST = CW'(CONFIRM_BITS - 1);
  localparam logic [MW-1:0] MISS_LAST  = MW'(LOSS_THRESH - 1);
  localparam logic [4:0]    FILL_LAST  = 5'd15;
  localparam logic [15:0]   LOCKUP     = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_sr;
  logic [4:0]      r_fill_cnt;
  logic [CW-1:0]   r_match_cnt;
  logic [MW-1:0]   r_miss_cnt;
  logic            r_locked;
  logic            r_err;

  logic            w_pred;
  logic            w_mismatch;
  logic [15:0]     w_sr_rx;
  logic [15:0]     w_sr_pred;
  logic            w_count_err;

  assign w_pred      = ~(r_sr[15] ^ r_sr[4]);
  assign w_mismatch  = i_bit ^ w_pred;
  assign w_sr_rx     = {r_sr[14:0], i_bit};
  assign w_sr_pred   = {r_sr[14:0], w_pred};
  assign w_count_err = i_valid && (r_state == ST_LOCKED) && w_mismatch;

  // While locked the register free-runs on its own prediction, so a corrupted
  // bit on the link cannot poison the predictions that follow it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_FILL;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        unique case (r_state)
          ST_FILL: begin
            r_sr <= w_sr_rx;
            if (r_fill_cnt == FILL_LAST) begin
              r_fill_cnt <= '0;
              if (w_sr_rx != LOCKUP) begin
                r_state     <= ST_CONFIRM;
                r_match_cnt <= '0;
              end
            end else begin
              r_fill_cnt <= r_fill_cnt + 5'd1;
            end
          end

          ST_CONFIRM: begin
            r_sr <= w_sr_rx;
            if (!w_mismatch) begin
              if (r_match_cnt == MATCH_LAST) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
              end
            end else begin
              r_state     <= ST_FILL;
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
            end
          end

          ST_LOCKED: begin
            r_sr <= w_sr_pred;
            if (w_mismatch) begin
              r_err <= 1'b1;
              if (r_miss_cnt == MISS_LAST) begin
                r_state     <= ST_FILL;
                r_locked    <= 1'b0;
                r_fill_cnt  <= '0;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end

          default: begin
            r_state    <= ST_FILL;
            r_locked   <= 1'b0;
            r_fill_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHECK_ERRCNT_EN
  logic [15:0] r_err_count;

  // A clear coinciding with a counted error leaves that one error on record.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_count <= '0;
    end else if (i_clr) begin
      r_err_count <= w_count_err ? 16'd1 : 16'd0;
    end else if (w_count_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr;
  assign o_err_count  = 16'h0000;
`endif

  assign o_locked      = r_locked;
  assign o_err         = r_err;
  assign o_state_value = r_sr;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side counterpart of the game's 16-bit LFSR random source. Consumes a serial bit stream produced by that LFSR and self-synchronises a local copy of its state. Once locked, it predicts every following bit and counts mismatches. Used in-system to check the random source and the bit links it drives, and in benches as the reference checker.

## Interface
- Parameters:
  - CONFIRM_BITS, default 16: consecutive matching bits required after fill before lock.
  - LOSS_THRESH, default 4: consecutive mismatches in LOCKED that drop lock.
- Ports:
  - i_clk  in  1  single clock; all logic on rising edge.
  - i_rst  in  1  reset, synchronous, active-high.
  - i_valid  in  1  i_bit is valid this cycle; when low, all state holds.
  - i_bit  in  1  received stream bit.
  - i_clr  in  1  clears o_err_count; ignored while i_rst is high.
  - o_locked  out  1  high in LOCKED state.
  - o_err  out  1  one-cycle pulse per mismatched bit counted.
  - o_err_count  out  16  saturating error count.
  - o_state_value  out  16  reconstructed LFSR state (shift register).

## Operation
- Generator model: next state = {s[14:0], fb}, where fb = ~(s[15] ^ s[4]). The emitted stream bit is fb, the new LSB.
- Shift register sr, 16 bits. Predicted bit p = ~(sr[15] ^ sr[4]). All state below advances only on cycles where i_valid = 1.
- FILL state:
  - Shift i_bit into sr (sr <= {sr[14:0], i_bit}) and increment fill_cnt.
  - After the 16th bit, go to CONFIRM, unless the resulting sr == 16'hFFFF. That is the XNOR lock-up state, so stay in FILL with fill_cnt = 0.
- CONFIRM state:
  - Shift i_bit into sr.
  - If i_bit == p, increment match_cnt. On the CONFIRM_BITS-th consecutive match, go to LOCKED.
  - If i_bit != p, go to FILL with fill_cnt = 0 and match_cnt = 0. sr keeps shifting as normal.
  - No errors are counted in CONFIRM.
- LOCKED state:
  - Shift p, not i_bit (sr <= {sr[14:0], p}), so one bad bit does not corrupt later predictions.
  - If i_bit != p: pulse o_err, increment o_err_count (saturating at 16'hFFFF), increment miss_cnt.
  - If i_bit == p: set miss_cnt = 0.
  - When miss_cnt reaches LOSS_THRESH, go to FILL with all internal counters zeroed.
- o_err_count:
  - Keeps its value across loss of lock.
  - Cleared by i_rst or i_clr.
  - If i_clr and a counted error occur in the same cycle, the result is 1.
- Reset mid-operation:
  - State returns to FILL; sr, all counters, o_locked, o_err and o_err_count go to 0 on the next edge.
  - i_rst overrides i_valid and i_clr.
- Reset values: o_locked = 0, o_err = 0, o_err_count = 0, o_state_value = 0.

## Timing
- All outputs are registered. They reflect the valid bit sampled at edge N from edge N onward (visible in cycle N+1).
- o_locked rises at the edge sampling the (16 + CONFIRM_BITS)-th valid bit of a clean stream. It falls at the edge sampling the LOSS_THRESH-th consecutive mismatch.
- o_err is high for exactly one cycle per counted error. It is low on cycles with i_valid = 0.
- No backpressure: a bit is accepted every cycle that i_valid is high. Throughput is 1 bit/cycle.

## Configuration
- LFSR_CHECK_ERRCNT_EN:
  - Defined: error counter and i_clr logic are present as described above.
  - Undefined: o_err_count is tied to 16'h0000 and i_clr is ignored. o_err, locking and loss-of-lock are unchanged; miss_cnt remains.

## Test plan
- Reset, then feed the stream from a generator seeded 16'h1314 with i_valid always high → o_locked = 1 after bit 32, o_err_count = 0, and o_state_value equals the generator state on every following cycle.
- Locked, invert one bit → single o_err pulse, o_err_count = 1, o_locked stays 1, subsequent clean bits give no further errors.
- Locked, invert 4 consecutive bits → o_err_count = 4, o_locked = 0 after the 4th; 32 further clean bits → relocked, count still 4.
- Clean stream with i_valid toggled 1/0 every cycle → lock after 32 valid bits (64 cycles); state and outputs frozen on invalid cycles.
- Constant i_bit = 1 for 100 bits → o_locked never asserts, o_err_count = 0.
- Locked with o_err_count = 3: assert i_clr on the same cycle as an inverted bit → count = 1. i_rst mid-CONFIRM → all outputs 0; relocks 32 bits after reset is released.
